// File: rtl/stmm_out_packer.sv
// ---------------------------------------------------------------------------
// stmm_out_packer
//
// Output-side companion to the STMM vector-vector MAC unit. Takes one signed
// DQ-bit dot-product result per beat and requantizes it:
//   P = C_in * mult
//   R = round-half-up(P / 2^shift)
//   S = R + z_C
//   clamp S to Q bits
// N consecutive results are packed into one N*Q-bit vector, with element k at
// O_out[Q*k +: Q]. The vector is then handed downstream on a valid/ready
// handshake.
//
// Pipeline: the product is registered one cycle after accept. The rounded,
// offset and saturated element is written into its output slot two cycles
// after accept. o_valid rises on the same edge that writes slot N-1.
//
// Build option:
//   STMM_PACK_RELU_EN - when defined, the saturation lower bound becomes
//                       max(z_C, -2^(Q-1)), which fuses a quantized ReLU.
//
// Ports:
//   clk      system clock; all logic on the rising edge
//   rst_n    asynchronous active-low reset
//   C_in     signed DQ-bit accumulator result
//   c_valid  C_in is valid this cycle
//   c_ready  block can accept C_in this cycle
//   mult     unsigned MW-bit requant scale
//   shift    SW-bit requant right-shift amount
//   z_C      signed Q-bit output zero point
//   O_out    packed N*Q-bit output vector
//   o_valid  O_out holds a complete vector
//   o_ready  downstream accepts O_out
// ---------------------------------------------------------------------------
module stmm_out_packer #(
    parameter int unsigned N  = 44,
    parameter int unsigned Q  = 8,
    parameter int unsigned DQ = 18,
    parameter int unsigned MW = 16,
    parameter int unsigned SW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DQ-1:0] C_in,
    input  logic                 c_valid,
    output logic                 c_ready,
    input  logic [MW-1:0]        mult,
    input  logic [SW-1:0]        shift,
    input  logic signed [Q-1:0]  z_C,
    output logic [N*Q-1:0]       O_out,
    output logic                 o_valid,
    input  logic                 o_ready
);

    // Counters must be able to hold N itself (acc_cnt == N means "all accepted").
    localparam int unsigned CW  = $clog2(N + 1);
    // The product of a signed DQ-bit value and a zero-extended MW-bit value.
    localparam int unsigned PW  = DQ + MW + 1;
    // One extra bit so that adding the rounding bias can never wrap.
    localparam int unsigned RW  = PW + 1;
    // One further bit for the zero-point addition.
    localparam int unsigned SSW = RW + 1;

    localparam logic signed [SSW-1:0] SatHi = SSW'(2 ** (Q - 1) - 1);
    // -2^(Q-1) is the bitwise complement of 2^(Q-1)-1.
    localparam logic signed [SSW-1:0] SatLo = ~SatHi;

    typedef enum logic [0:0] {
        StFill,
        StFull
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CW-1:0]         acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]  p_q, p_d;
    logic [N*Q-1:0]        o_out_q, o_out_d;
    logic                  o_valid_q, o_valid_d;

    // -----------------------------------------------------------------------
    // Stage-2 datapath: round, add zero point, saturate
    // -----------------------------------------------------------------------
    logic signed [RW-1:0]  p_ext;
    logic signed [RW-1:0]  bias;
    logic signed [RW-1:0]  r_val;
    logic signed [SSW-1:0] z_ext;
    logic signed [SSW-1:0] s_val;
    logic signed [SSW-1:0] sat_lo;
    logic [Q-1:0]          res;

    always_comb begin
        p_ext = $signed({p_q[PW-1], p_q});

        // With shift == 0 the bias is zero and the shift is a no-op, so R = P.
        bias = '0;
        if (shift != '0) begin
            bias = $signed(RW'(1)) << (shift - SW'(1));
        end
        r_val = (p_ext + bias) >>> shift;

        z_ext = $signed({{(SSW - Q){z_C[Q-1]}}, z_C});
        s_val = $signed({r_val[RW-1], r_val}) + z_ext;

`ifdef STMM_PACK_RELU_EN
        sat_lo = (z_ext > SatLo) ? z_ext : SatLo;
`else
        sat_lo = SatLo;
`endif

        if (s_val > SatHi) begin
            res = SatHi[Q-1:0];
        end else if (s_val < sat_lo) begin
            res = sat_lo[Q-1:0];
        end else begin
            res = s_val[Q-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic and handshake outputs
    // -----------------------------------------------------------------------
    logic accept;
    logic last_write;

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        s1_valid_d = 1'b0;
        p_d        = p_q;
        o_out_d    = o_out_q;
        o_valid_d  = o_valid_q;

        c_ready    = (state_q == StFill) && (acc_cnt_q < CW'(N));
        accept     = c_valid && c_ready;
        last_write = s1_valid_q && (wr_cnt_q == CW'(N - 1));

        // Stage 1: accept a beat and register its product.
        if (accept) begin
            acc_cnt_d  = acc_cnt_q + CW'(1);
            s1_valid_d = 1'b1;
            p_d        = $signed({{(PW - DQ){C_in[DQ-1]}}, C_in})
                       * $signed({{(PW - MW){1'b0}}, mult});
        end

        // Stage 2: write the requantized element into its slot.
        if (s1_valid_q) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (wr_cnt_q == CW'(k)) begin
                    o_out_d[Q*k +: Q] = res;
                end
            end
            wr_cnt_d = wr_cnt_q + CW'(1);
        end

        if (last_write) begin
            state_d   = StFull;
            o_valid_d = 1'b1;
        end

        // In FULL nothing is accepted and the pipeline is empty, so the
        // handshake can safely rewind both counters.
        if ((state_q == StFull) && o_ready) begin
            state_d   = StFill;
            o_valid_d = 1'b0;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            o_out_q    <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            o_out_q    <= o_out_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign O_out   = o_out_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_stmm_out_packer.sv
module tb_stmm_out_packer;

    localparam int unsigned N  = 4;
    localparam int unsigned Q  = 8;
    localparam int unsigned DQ = 18;
    localparam int unsigned MW = 16;
    localparam int unsigned SW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DQ-1:0] c_in;
    logic                 c_valid;
    logic                 c_ready;
    logic [MW-1:0]        mult;
    logic [SW-1:0]        shift;
    logic signed [Q-1:0]  z_c;
    logic [N*Q-1:0]       o_out;
    logic                 o_valid;
    logic                 o_ready;

    int checks = 0;
    int fails  = 0;

    int             cur_vals [N];
    logic [N*Q-1:0] exp_out;

    always #5 clk = ~clk;

    stmm_out_packer #(
        .N (N),
        .Q (Q),
        .DQ(DQ),
        .MW(MW),
        .SW(SW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .C_in   (c_in),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .mult   (mult),
        .shift  (shift),
        .z_C    (z_c),
        .O_out  (o_out),
        .o_valid(o_valid),
        .o_ready(o_ready)
    );

    // Reference requantization from the arithmetic definition:
    // floor((c*m + 2^(sh-1)) / 2^sh) + z, then clamp.
    function automatic logic [7:0] model_rq(input longint c, input longint m,
                                            input int sh, input longint z);
        longint p, num, d, r, s, lo;
        p = c * m;
        if (sh == 0) begin
            r = p;
        end else begin
            d   = longint'(1) << sh;
            num = p + d / 2;
            r   = num / d;
            if ((num % d != 0) && (num < 0)) r = r - 1;
        end
        s  = r + z;
        lo = -128;
`ifdef STMM_PACK_RELU_EN
        if (z > lo) lo = z;
`endif
        if (s > 127) s = 127;
        if (s < lo)  s = lo;
        return s[7:0];
    endfunction

    task automatic compute_expected();
        for (int i = 0; i < N; i++) begin
            exp_out[Q*i +: Q] = model_rq(longint'(cur_vals[i]), longint'(mult),
                                         int'(shift), longint'(z_c));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Feed cur_vals as N accepted beats; returns one step after the last accept edge.
    task automatic push_vector(input int max_gap);
        for (int i = 0; i < N; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            c_valid = 1'b0;
            repeat (gap) cycle();
            c_in    = DQ'(cur_vals[i]);
            c_valid = 1'b1;
            checks++;
            if (c_ready !== 1'b1) begin
                fails++;
                $display("FAIL push_ready beat %0d: c_ready=%b, expected 1", i, c_ready);
            end
            cycle();
        end
        c_valid = 1'b0;
    endtask

    task automatic check_complete(input string name);
        checks++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s latency_early: o_valid=%b, expected 0", name, o_valid);
        end
        checks++;
        if (c_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_after_last: c_ready=%b, expected 0", name, c_ready);
        end
        cycle();
        checks++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: o_valid=%b, expected 1", name, o_valid);
        end
        checks++;
        if (o_out !== exp_out) begin
            fails++;
            $display("FAIL %s data: O_out=%h, expected %h", name, o_out, exp_out);
        end
    endtask

    task automatic consume(input string name);
        o_ready = 1'b1;
        cycle();
        o_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s release_valid: o_valid=%b, expected 0", name, o_valid);
        end
        checks++;
        if (c_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s release_ready: c_ready=%b, expected 1", name, c_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_out !== '0 || o_valid !== 1'b0 || c_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_initial: O_out=%h o_valid=%b c_ready=%b, expected 0/0/1",
                     o_out, o_valid, c_ready);
        end
        mult = 16'd1; shift = '0; z_c = 8'sd0;
        cur_vals = '{9, 8, 7, 6};
        compute_expected();
        push_vector(0);
        check_complete("reset_fill");
        // Assert reset in the middle of a cycle: outputs must clear at once.
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (o_out !== '0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: O_out=%h o_valid=%b, expected 0/0", o_out, o_valid);
        end
        #2 rst_n = 1'b1;
        cycle();
        checks++;
        if (c_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: c_ready=%b o_valid=%b, expected 1/0", c_ready, o_valid);
        end
    endtask

    task automatic test_packing();
        mult = 16'd1; shift = '0; z_c = 8'sd0;
        cur_vals = '{1, 2, 3, 4};
        compute_expected();
        push_vector(0);
        check_complete("packing");
        checks++;
        if (o_out !== 32'h04030201) begin
            fails++;
            $display("FAIL packing_const: O_out=%h, expected 04030201", o_out);
        end
        consume("packing");
    endtask

    task automatic test_rounding();
        mult = 16'd3; shift = 5'd2; z_c = 8'sd0;
        cur_vals = '{5, -5, 6, 6};
        compute_expected();
        push_vector(1);
        check_complete("rounding");
        checks++;
`ifdef STMM_PACK_RELU_EN
        if (o_out !== 32'h05050004) begin
            fails++;
            $display("FAIL rounding_const: O_out=%h, expected 05050004", o_out);
        end
`else
        if (o_out !== 32'h0505FC04) begin
            fails++;
            $display("FAIL rounding_const: O_out=%h, expected 0505fc04", o_out);
        end
`endif
        consume("rounding");
    endtask

    task automatic test_saturation();
        mult = 16'd1; shift = '0; z_c = 8'sd10;
        cur_vals = '{200, -300, 5, 117};
        compute_expected();
        push_vector(0);
        check_complete("saturation");
        checks++;
`ifdef STMM_PACK_RELU_EN
        if (o_out !== 32'h7F0F0A7F) begin
            fails++;
            $display("FAIL saturation_const: O_out=%h, expected 7f0f0a7f", o_out);
        end
`else
        if (o_out !== 32'h7F0F807F) begin
            fails++;
            $display("FAIL saturation_const: O_out=%h, expected 7f0f807f", o_out);
        end
`endif
        consume("saturation");
    endtask

    task automatic test_backpressure();
        logic [N*Q-1:0] held;
        mult = 16'd2; shift = 5'd1; z_c = -8'sd3;
        for (int i = 0; i < N; i++) cur_vals[i] = int'($urandom_range(0, 200)) - 100;
        compute_expected();
        held = exp_out;
        push_vector(0);
        check_complete("backpressure");
        for (int i = 0; i < 5; i++) begin
            c_in    = DQ'(int'($urandom_range(0, 1000)));
            c_valid = 1'b1;
            cycle();
            checks++;
            if (o_valid !== 1'b1 || c_ready !== 1'b0 || o_out !== held) begin
                fails++;
                $display("FAIL backpressure_hold %0d: o_valid=%b c_ready=%b O_out=%h, expected 1/0/%h",
                         i, o_valid, c_ready, o_out, held);
            end
        end
        // Handshake cycle with c_valid still high: the beat must be ignored.
        consume("backpressure");
        c_valid = 1'b0;
        mult = 16'd1; shift = '0; z_c = 8'sd0;
        cur_vals = '{11, 22, 33, 44};
        compute_expected();
        push_vector(0);
        check_complete("after_backpressure");
        consume("after_backpressure");
    endtask

    task automatic test_reset_mid_fill();
        mult = 16'd1; shift = '0; z_c = 8'sd0;
        for (int i = 0; i < 3; i++) begin
            c_in    = DQ'(50 + i);
            c_valid = 1'b1;
            cycle();
        end
        c_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_out !== '0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL midfill_reset: O_out=%h o_valid=%b, expected 0/0", o_out, o_valid);
        end
        #1 rst_n = 1'b1;
        cycle();
        cur_vals = '{-1, 2, -3, 4};
        compute_expected();
        push_vector(0);
        check_complete("midfill_fresh");
        consume("midfill_fresh");
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL midfill_single_valid %0d: o_valid=%b, expected 0", i, o_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int v = 0; v < 8; v++) begin
            mult  = MW'($urandom);
            shift = SW'($urandom_range(0, 31));
            z_c   = Q'($urandom);
            for (int i = 0; i < N; i++) begin
                cur_vals[i] = int'($urandom_range(0, 262143)) - 131072;
            end
            compute_expected();
            push_vector(v % 3);
            check_complete("random");
            repeat (int'($urandom_range(0, 3))) begin
                cycle();
                checks++;
                if (o_valid !== 1'b1 || o_out !== exp_out) begin
                    fails++;
                    $display("FAIL random_hold: o_valid=%b O_out=%h, expected 1/%h",
                             o_valid, o_out, exp_out);
                end
            end
            consume("random");
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        c_in    = '0;
        c_valid = 1'b0;
        mult    = '0;
        shift   = '0;
        z_c     = '0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle();

        test_reset();
        test_packing();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid_fill();
        test_random();

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule
